// File: rtl/cop0_info_pkg.sv
// Shared COP0 register selectors and Cause/Status bit positions.
package cop0_info;

    localparam logic [4:0] RD_COUNT    = 5'd9;
    localparam logic [4:0] RD_COMPARE  = 5'd11;
    localparam logic [2:0] SEL_COUNT   = 3'd0;
    localparam logic [2:0] SEL_COMPARE = 3'd0;

    localparam int IDX_STATUS_IE   = 0;
    localparam int IDX_STATUS_EXL  = 1;
    localparam int IDX_STATUS_ERL  = 2;
    localparam int IDX_STATUS_IM_S = 8;
    localparam int IDX_STATUS_IM_E = 15;

    localparam int IDX_CAUSE_IP_S  = 8;
    localparam int IDX_CAUSE_TI    = 30;
    localparam int IP_HW_BASE      = 2;
    localparam int IP_TIMER        = 7;

    // Global interrupt enable: IE set and neither exception nor error level active.
    function automatic logic irq_globally_enabled(input logic [31:0] status);
        return status[IDX_STATUS_IE] && !status[IDX_STATUS_EXL] && !status[IDX_STATUS_ERL];
    endfunction

endpackage

// File: rtl/cop0_timer_irq_sync.sv
// Two-flop, width-parameterised synchroniser with asynchronous reset.
module irq_sync #(
    parameter int DATA_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] sync_p0;
    logic [DATA_W-1:0] sync_p1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= d;
            sync_p1 <= sync_p0;
        end
    end

    assign q = sync_p1;

endmodule

// File: rtl/cop0_timer_irq.sv
// COP0 Count/Compare timer, hardware interrupt synchronisation and masked irq.
// Build option: COP0_COUNT_DIV2_EN makes Count advance every second clock.
module cop0_timer_irq
    import cop0_info::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  wr_rd,
    input  logic [2:0]  wr_sel,
    input  logic [31:0] wr_data,
    input  logic [31:0] status,
    input  logic [1:0]  sw_ip,
    input  logic [5:0]  hw_int,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti,
    output logic [5:0]  ip_hw,
    output logic        irq
);

    logic        count_wr;
    logic        compare_wr;
    logic        inc;
    logic [31:0] count_next;
    logic [5:0]  hw_sync;
    logic [7:0]  pending;
    logic [7:0]  im;
    logic        irq_next;
    logic        unused_status;

    assign count_wr   = we && (wr_rd == RD_COUNT)   && (wr_sel == SEL_COUNT);
    assign compare_wr = we && (wr_rd == RD_COMPARE) && (wr_sel == SEL_COMPARE);
    assign count_next = count + 32'd1;

`ifdef COP0_COUNT_DIV2_EN
    logic phase;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase <= 1'b0;
        end else begin
            phase <= count_wr ? 1'b0 : ~phase;
        end
    end

    assign inc = phase;
`else
    assign inc = 1'b1;
`endif

    // Count write beats increment; Compare write beats a simultaneous match.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count   <= '0;
            compare <= '0;
            ti      <= 1'b0;
        end else begin
            if (count_wr) begin
                count <= wr_data;
            end else if (inc) begin
                count <= count_next;
            end
            if (compare_wr) begin
                compare <= wr_data;
                ti      <= 1'b0;
            end else if (!count_wr && inc && (count_next == compare)) begin
                ti <= 1'b1;
            end
        end
    end

    irq_sync #(.DATA_W(6)) u_irq_sync (
        .clk   (clk),
        .reset (reset),
        .d     (hw_int),
        .q     (hw_sync)
    );

    always_comb begin
        ip_hw = hw_sync;
        ip_hw[IP_TIMER-IP_HW_BASE] = hw_sync[IP_TIMER-IP_HW_BASE] | ti;
    end

    assign pending  = {ip_hw, sw_ip};
    assign im       = status[IDX_STATUS_IM_E:IDX_STATUS_IM_S];
    assign irq_next = irq_globally_enabled(status) && (|(pending & im));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq <= 1'b0;
        end else begin
            irq <= irq_next;
        end
    end

    assign unused_status = ^{status[31:16], status[7:3]};

endmodule

// File: tb/tb_cop0_timer_irq.sv
// Table-driven, scoreboarded bench for cop0_timer_irq.
module tb_cop0_timer_irq;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [4:0]  wr_rd;
    logic [2:0]  wr_sel;
    logic [31:0] wr_data;
    logic [31:0] status;
    logic [1:0]  sw_ip;
    logic [5:0]  hw_int;
    logic [31:0] count;
    logic [31:0] compare;
    logic        ti;
    logic [5:0]  ip_hw;
    logic        irq;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] status;
        logic [1:0]  sw_ip;
        logic [5:0]  hw_int;
        logic        chk_count;
        logic [31:0] e_count;
        logic [31:0] e_compare;
        logic        e_ti;
        logic [5:0]  e_ip;
        logic        e_irq;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    cop0_timer_irq dut (
        .clk     (clk),
        .reset   (reset),
        .we      (we),
        .wr_rd   (wr_rd),
        .wr_sel  (wr_sel),
        .wr_data (wr_data),
        .status  (status),
        .sw_ip   (sw_ip),
        .hw_int  (hw_int),
        .count   (count),
        .compare (compare),
        .ti      (ti),
        .ip_hw   (ip_hw),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic w, input logic [4:0] rd, input logic [31:0] d,
                                input logic [31:0] st, input logic [1:0] sw, input logic [5:0] hw,
                                input logic cc, input logic [31:0] ec, input logic [31:0] ecmp,
                                input logic eti, input logic [5:0] eip, input logic eirq);
        vec_t v;
        v.we = w; v.rd = rd; v.data = d; v.status = st; v.sw_ip = sw; v.hw_int = hw;
        v.chk_count = cc; v.e_count = ec; v.e_compare = ecmp;
        v.e_ti = eti; v.e_ip = eip; v.e_irq = eirq;
        return v;
    endfunction

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        @(negedge clk);
        we = v.we; wr_rd = v.rd; wr_sel = 3'd0; wr_data = v.data;
        status = v.status; sw_ip = v.sw_ip; hw_int = v.hw_int;
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        if (e.chk_count) chk32($sformatf("v%0d count", idx), count, e.e_count);
        chk32($sformatf("v%0d compare", idx), compare, e.e_compare);
        chk32($sformatf("v%0d ti", idx), {31'd0, ti}, {31'd0, e.e_ti});
        chk32($sformatf("v%0d ip_hw", idx), {26'd0, ip_hw}, {26'd0, e.e_ip});
        chk32($sformatf("v%0d irq", idx), {31'd0, irq}, {31'd0, e.e_irq});
    endtask

    localparam logic [4:0] CNT = 5'd9;
    localparam logic [4:0] CMP = 5'd11;
    localparam logic [4:0] NOP = 5'd0;

    initial begin
        reset = 1'b1; we = 1'b0; wr_rd = '0; wr_sel = '0; wr_data = '0;
        status = '0; sw_ip = '0; hw_int = '0;
        repeat (2) @(negedge clk);
        chk32("reset count", count, 32'd0);
        chk32("reset compare", compare, 32'd0);
        chk32("reset ti/ip/irq", {24'd0, ti, ip_hw, irq}, 32'd0);
        reset = 1'b0;

`ifdef COP0_COUNT_DIV2_EN
        tbl.push_back(mk(1, CNT, 32'h100, 0, 0, 0, 1, 32'h100, 0, 0, 0, 0));
        tbl.push_back(mk(0, NOP, 0,       0, 0, 0, 1, 32'h100, 0, 0, 0, 0));
        tbl.push_back(mk(0, NOP, 0,       0, 0, 0, 1, 32'h101, 0, 0, 0, 0));
        tbl.push_back(mk(0, NOP, 0,       0, 0, 0, 1, 32'h101, 0, 0, 0, 0));
        tbl.push_back(mk(0, NOP, 0,       0, 0, 0, 1, 32'h102, 0, 0, 0, 0));
        tbl.push_back(mk(1, CNT, 32'h200, 0, 0, 0, 1, 32'h200, 0, 0, 0, 0));
        tbl.push_back(mk(0, NOP, 0,       0, 0, 0, 1, 32'h200, 0, 0, 0, 0));
        tbl.push_back(mk(0, NOP, 0,       0, 0, 0, 1, 32'h201, 0, 0, 0, 0));
`else
        // Count write then match at 0x10
        tbl.push_back(mk(1, CMP, 32'h10, 32'h0,    0, 0, 0, 0,     32'h10, 0, 6'h00, 0));
        tbl.push_back(mk(1, CNT, 32'h0D, 32'h8001, 0, 0, 1, 32'h0D, 32'h10, 0, 6'h00, 0));
        tbl.push_back(mk(0, NOP, 0,      32'h8001, 0, 0, 1, 32'h0E, 32'h10, 0, 6'h00, 0));
        tbl.push_back(mk(0, NOP, 0,      32'h8001, 0, 0, 1, 32'h0F, 32'h10, 0, 6'h00, 0));
        tbl.push_back(mk(0, NOP, 0,      32'h8001, 0, 0, 1, 32'h10, 32'h10, 1, 6'h20, 0));
        tbl.push_back(mk(0, NOP, 0,      32'h8001, 0, 0, 1, 32'h11, 32'h10, 1, 6'h20, 1));
        // Compare write clears ti
        tbl.push_back(mk(1, CMP, 32'h20, 32'h8001, 0, 0, 1, 32'h12, 32'h20, 0, 6'h00, 1));
        tbl.push_back(mk(0, NOP, 0,      32'h8001, 0, 0, 1, 32'h13, 32'h20, 0, 6'h00, 0));
        // Compare write on the exact match cycle wins
        tbl.push_back(mk(1, CNT, 32'h1E, 32'h8001, 0, 0, 1, 32'h1E, 32'h20, 0, 6'h00, 0));
        tbl.push_back(mk(0, NOP, 0,      32'h8001, 0, 0, 1, 32'h1F, 32'h20, 0, 6'h00, 0));
        tbl.push_back(mk(1, CMP, 32'h40, 32'h8001, 0, 0, 1, 32'h20, 32'h40, 0, 6'h00, 0));
        tbl.push_back(mk(0, NOP, 0,      32'h8001, 0, 0, 1, 32'h21, 32'h40, 0, 6'h00, 0));
        // Wrap through 0xFFFFFFFF, match at 1
        tbl.push_back(mk(1, CNT, 32'hFFFF_FFFE, 32'h8001, 0, 0, 1, 32'hFFFF_FFFE, 32'h40, 0, 6'h00, 0));
        tbl.push_back(mk(1, CMP, 32'h1,  32'h8001, 0, 0, 1, 32'hFFFF_FFFF, 32'h1, 0, 6'h00, 0));
        tbl.push_back(mk(0, NOP, 0,      32'h8001, 0, 0, 1, 32'h0, 32'h1, 0, 6'h00, 0));
        tbl.push_back(mk(0, NOP, 0,      32'h8001, 0, 0, 1, 32'h1, 32'h1, 1, 6'h20, 0));
        tbl.push_back(mk(0, NOP, 0,      32'h8001, 0, 0, 1, 32'h2, 32'h1, 1, 6'h20, 1));
        // Global masking of the timer interrupt
        tbl.push_back(mk(0, NOP, 0,      32'h8003, 0, 0, 1, 32'h3, 32'h1, 1, 6'h20, 0));
        tbl.push_back(mk(0, NOP, 0,      32'h8005, 0, 0, 1, 32'h4, 32'h1, 1, 6'h20, 0));
        tbl.push_back(mk(0, NOP, 0,      32'h0001, 0, 0, 1, 32'h5, 32'h1, 1, 6'h20, 0));
        tbl.push_back(mk(1, CMP, 32'h1000, 32'h0,  0, 0, 1, 32'h6, 32'h1000, 0, 6'h00, 0));
        // hw_int[0] through the synchroniser onto IP2
        tbl.push_back(mk(0, NOP, 0,      32'h0401, 0, 6'h01, 1, 32'h7, 32'h1000, 0, 6'h00, 0));
        tbl.push_back(mk(0, NOP, 0,      32'h0401, 0, 6'h01, 1, 32'h8, 32'h1000, 0, 6'h01, 0));
        tbl.push_back(mk(0, NOP, 0,      32'h0401, 0, 6'h01, 1, 32'h9, 32'h1000, 0, 6'h01, 1));
        tbl.push_back(mk(0, NOP, 0,      32'h0403, 0, 6'h01, 1, 32'hA, 32'h1000, 0, 6'h01, 0));
        tbl.push_back(mk(0, NOP, 0,      32'h0405, 0, 6'h01, 1, 32'hB, 32'h1000, 0, 6'h01, 0));
        tbl.push_back(mk(0, NOP, 0,      32'h0001, 0, 6'h01, 1, 32'hC, 32'h1000, 0, 6'h01, 0));
        tbl.push_back(mk(0, NOP, 0,      32'h0401, 0, 6'h00, 1, 32'hD, 32'h1000, 0, 6'h01, 1));
        tbl.push_back(mk(0, NOP, 0,      32'h0401, 0, 6'h00, 1, 32'hE, 32'h1000, 0, 6'h00, 1));
        tbl.push_back(mk(0, NOP, 0,      32'h0401, 0, 6'h00, 1, 32'hF, 32'h1000, 0, 6'h00, 0));
        // Software interrupt on IP1
        tbl.push_back(mk(0, NOP, 0,      32'h0201, 2'b10, 0, 1, 32'h10, 32'h1000, 0, 6'h00, 1));
        tbl.push_back(mk(0, NOP, 0,      32'h0201, 2'b00, 0, 1, 32'h11, 32'h1000, 0, 6'h00, 0));
        // Write to an unrelated register is ignored
        tbl.push_back(mk(1, 5'd12, 32'hDEAD, 32'h0, 0, 0, 1, 32'h12, 32'h1000, 0, 6'h00, 0));
        // Set up the mid-run reset case: count 0x1234..0x1236 with ti
        tbl.push_back(mk(1, CNT, 32'h1234, 32'h0, 0, 0, 1, 32'h1234, 32'h1000, 0, 6'h00, 0));
        tbl.push_back(mk(1, CMP, 32'h1236, 32'h0, 0, 0, 1, 32'h1235, 32'h1236, 0, 6'h00, 0));
        tbl.push_back(mk(0, NOP, 0,      32'h8001, 0, 0, 1, 32'h1236, 32'h1236, 1, 6'h20, 0));
        tbl.push_back(mk(0, NOP, 0,      32'h8001, 0, 0, 1, 32'h1237, 32'h1236, 1, 6'h20, 1));
`endif

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], i);
        end

        // Asynchronous reset mid-run, away from any clock edge
        @(negedge clk);
        we = 1'b0;
        reset = 1'b1;
        #1;
        chk32("midrun reset count", count, 32'd0);
        chk32("midrun reset compare", compare, 32'd0);
        chk32("midrun reset ti/ip/irq", {24'd0, ti, ip_hw, irq}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, limit 200000");
        $fatal(1);
    end

endmodule
